// File: rtl/irq_ctrl.sv
// Edge-triggered interrupt controller: latches rising edges of irq_in into a pending
// register, requests the lowest-index unmasked pending line, and tracks the handler.
module irq_ctrl #(
  parameter int N_IRQ = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_we,
  input  logic [N_IRQ-1:0] mask_wdata,
  input  logic             ir_en,
  input  logic             ir_ack,
  input  logic             eret,
  output logic             ir_req,
  output logic [2:0]       cause,
  output logic [N_IRQ-1:0] pending,
  output logic [N_IRQ-1:0] mask,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [N_IRQ-1:0] prev_q, prev_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] mask_q, mask_d;
  logic [2:0]       cause_q, cause_d;
  logic             ir_req_q, ir_req_d;
  logic             busy_q, busy_d;
  logic [N_IRQ-1:0] rise_s;
  logic [N_IRQ-1:0] clr_s;
  logic [N_IRQ-1:0] elig_s;

  // Scan from the top so the lowest set index is the one that sticks.
  function automatic logic [2:0] lowest_idx(input logic [N_IRQ-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      idx = v[i] ? 3'(i) : idx;
    end
    return idx;
  endfunction

  // Next-state, pending/mask update and registered output decode.
  always_comb begin
    rise_s   = irq_in & ~prev_q;
    elig_s   = pending_q & mask_q;
    prev_d   = irq_in;
    state_d  = state_q;
    cause_d  = cause_q;
    clr_s    = '0;
    mask_d   = mask_we ? mask_wdata : mask_q;

    case (state_q)
      IDLE: begin
        if (ir_en && (elig_s != '0)) begin
          state_d = REQ;
          cause_d = lowest_idx(elig_s);
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (ir_ack) begin
          state_d = SERVICE;
          for (int i = 0; i < N_IRQ; i++) begin
            clr_s[i] = (cause_q == 3'(i));
          end
        end else begin
          state_d = REQ;
        end
      end
      SERVICE: begin
        if (eret) begin
          state_d = IDLE;
        end else begin
          state_d = SERVICE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh edge on the line being acknowledged keeps its pending bit set.
    pending_d = (pending_q & ~clr_s) | rise_s;
    ir_req_d  = (state_d == REQ);
    busy_d    = (state_d == SERVICE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      prev_q    <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      cause_q   <= 3'd0;
      ir_req_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      cause_q   <= cause_d;
      ir_req_q  <= ir_req_d;
      busy_q    <= busy_d;
    end
  end

  assign ir_req  = ir_req_q;
  assign busy    = busy_q;
  assign cause   = cause_q;
  assign pending = pending_q;
  assign mask    = mask_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: each step drives inputs for one clock, queues the
// hand-derived expected outputs, and compares them just after the clock edge.
module tb_irq_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] irq_in;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       ir_en;
  logic       ir_ack;
  logic       eret;
  logic       ir_req;
  logic [2:0] cause;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      tag;
    logic       req;
    logic       bsy;
    logic [2:0] cse;
    logic [3:0] pnd;
    logic [3:0] msk;
  } exp_t;

  exp_t sb_q[$];

  irq_ctrl #(.N_IRQ(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .ir_en      (ir_en),
    .ir_ack     (ir_ack),
    .eret       (eret),
    .ir_req     (ir_req),
    .cause      (cause),
    .pending    (pending),
    .mask       (mask),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string tag, input string field, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, field, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue expected post-edge outputs, then check them.
  task automatic step(input string tag, input logic r, input logic [3:0] irq,
                      input logic mwe, input logic [3:0] mwd, input logic en,
                      input logic ack, input logic er,
                      input logic e_req, input logic e_busy, input logic [2:0] e_cause,
                      input logic [3:0] e_pend, input logic [3:0] e_mask);
    exp_t e;
    exp_t got;
    rst        = r;
    irq_in     = irq;
    mask_we    = mwe;
    mask_wdata = mwd;
    ir_en      = en;
    ir_ack     = ack;
    eret       = er;
    e.tag = tag; e.req = e_req; e.bsy = e_busy; e.cse = e_cause; e.pnd = e_pend; e.msk = e_mask;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    cmp(got.tag, "ir_req",  {3'b000, ir_req}, {3'b000, got.req});
    cmp(got.tag, "busy",    {3'b000, busy},   {3'b000, got.bsy});
    cmp(got.tag, "cause",   {1'b0, cause},    {1'b0, got.cse});
    cmp(got.tag, "pending", pending,          got.pnd);
    cmp(got.tag, "mask",    mask,             got.msk);
  endtask

  initial begin
    rst = 1'b1; irq_in = 4'h0; mask_we = 1'b0; mask_wdata = 4'h0;
    ir_en = 1'b0; ir_ack = 1'b0; eret = 1'b0;
    //    tag         rst  irq   mwe  mwd   en   ack  eret  req  busy cause pend  mask
    step("reset",     1'b1, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
    step("mask_all",  1'b0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'hF);
    // single line 2: pending after k, request after k+1
    step("l2_edge",   1'b0, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h4, 4'hF);
    step("l2_req",    1'b0, 4'h4, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 4'h4, 4'hF);
    step("l2_ack",    1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'h0, 4'hF);
    step("l2_eret",   1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 4'h0, 4'hF);
    // simultaneous lines 1 and 3: priority, then second after eret
    step("p_edge",    1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'hA, 4'hF);
    step("p_req1",    1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'hA, 4'hF);
    step("p_ack1",    1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h8, 4'hF);
    step("p_eret1",   1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'h8, 4'hF);
    step("p_req3",    1'b0, 4'hA, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 4'h8, 4'hF);
    step("p_ack3",    1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 4'h0, 4'hF);
    step("p_eret3",   1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd3, 4'h0, 4'hF);
    // masked line retained, unmasked later; mask change cannot withdraw request
    step("m_clear",   1'b0, 4'h0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'h0, 4'h0);
    step("m_pulse",   1'b0, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'h1, 4'h0);
    step("m_hold",    1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'h1, 4'h0);
    step("m_unmask",  1'b0, 4'h0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 4'h1, 4'h1);
    step("m_req0",    1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'h1, 4'h1);
    step("m_keepreq", 1'b0, 4'h0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'h1, 4'h0);
    step("m_ack0",    1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'h0, 4'h0);
    step("m_eret0",   1'b0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
    // ack with same-cycle re-edge, then a new line arrives during SERVICE
    step("r_mask",    1'b0, 4'h0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'hF);
    step("r_edge1",   1'b0, 4'h2, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h2, 4'hF);
    step("r_req1",    1'b0, 4'h0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'h2, 4'hF);
    step("r_ackedge", 1'b0, 4'h2, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h2, 4'hF);
    step("s_edge0",   1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'h3, 4'hF);
    step("s_nonest",  1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 4'h3, 4'hF);
    step("s_eret",    1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'h3, 4'hF);
    step("s_req0",    1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'h3, 4'hF);
    step("s_ack0",    1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'h2, 4'hF);
    step("s_eret0",   1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'h2, 4'hF);
    step("s_req1",    1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 4'h2, 4'hF);
    // reset mid-REQ, line held through reset counts as an edge afterwards
    step("x_rstreq",  1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
    step("x_heldedge",1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h3, 4'h0);
    step("x_idleign", 1'b0, 4'h3, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'h3, 4'h0);
    step("x_mask",    1'b0, 4'h3, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h3, 4'hF);
    step("x_noen",    1'b0, 4'h3, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h3, 4'hF);
    step("x_req0",    1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 4'h3, 4'hF);
    step("x_ack0",    1'b0, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 4'h2, 4'hF);
    step("x_rstsvc",  1'b1, 4'h3, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter: N_IRQ, default 4, number of external interrupt lines (legal 2..8).
REQ-002 Port: clk  input  1  main clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: irq_in  input  N_IRQ  raw interrupt lines, already synchronous to clk, level.
REQ-005 Port: mask_we  input  1  mask register write strobe.
REQ-006 Port: mask_wdata  input  N_IRQ  new mask value; bit=1 enables line.
REQ-007 Port: ir_en  input  1  pipeline may accept an interrupt this cycle.
REQ-008 Port: ir_ack  input  1  CP0 has taken the requested interrupt (jump issued).
REQ-009 Port: eret  input  1  ERET executed; handler finished.
REQ-010 Port: ir_req  output  1  interrupt request to CP0 interrupt input.
REQ-011 Port: cause  output  3  index of line being requested/serviced.
REQ-012 Port: pending  output  N_IRQ  pending register contents.
REQ-013 Port: mask  output  N_IRQ  mask register contents.
REQ-014 Port: busy  output  1  handler in progress (SERVICE state).

Function
REQ-015 Block SHALL keep a registered copy prev of irq_in; edge[i] = irq_in[i] & ~prev[i].
REQ-016 pending[i] SHALL set on the clock edge where edge[i]=1, regardless of mask or state.
REQ-017 pending[cause] SHALL clear on the edge where ir_ack=1 in REQ; if edge[cause]=1 same cycle, set wins (stays 1).
REQ-018 Masked pending bits SHALL be retained, not discarded; unmasking later makes them eligible.
REQ-019 mask SHALL load mask_wdata on edge with mask_we=1; new value used from the following cycle.
REQ-020 FSM states SHALL be IDLE, REQ, SERVICE, all outputs registered.
REQ-021 IDLE: if ir_en=1 and (pending & mask)!=0, go to REQ; cause <= lowest set index of pending & mask (index 0 highest priority).
REQ-022 IDLE: eret and ir_ack SHALL be ignored.
REQ-023 REQ: ir_req=1; cause held constant; request not withdrawn by mask changes or ir_en=0.
REQ-024 REQ: ir_ack=1 -> SERVICE; eret ignored.
REQ-025 SERVICE: busy=1, ir_req=0, cause held; eret=1 -> IDLE; ir_ack ignored; no nesting.
REQ-026 ir_req SHALL be 1 exactly while state=REQ; busy exactly while state=SERVICE.
REQ-027 Latency: line rising at sampling edge k (pending set at k) SHALL give ir_req=1 after edge k+1 if IDLE, ir_en=1, line unmasked.
REQ-028 After eret, next request SHALL be evaluated no earlier than the first cycle in IDLE (ir_req at earliest one cycle after busy falls).
REQ-029 Level held high SHALL produce one pending event only; re-arm requires low then high.
REQ-030 cause width 3 SHALL hold indices 0..N_IRQ-1; upper bits zero.

Reset
REQ-031 On rst=1 at an edge: state IDLE, pending=0, mask=0, prev=0, ir_req=0, busy=0, cause=0.
REQ-032 rst SHALL override all other inputs, including mid-REQ and mid-SERVICE (request dropped, pending cleared).
REQ-033 A line held high through reset SHALL register as an edge on the first edge after rst deasserts.

Verification
REQ-034 Reset, mask<=4'b1111, ir_en=1, irq_in[2] rises at edge k -> pending=4'b0100 after k, ir_req=1 and cause=2 after k+1.
REQ-035 pending=4'b1010 simultaneous, mask=4'b1111 -> cause=1 first; ack then eret -> cause=3 requested next.
REQ-036 mask=0, irq_in[0] pulses -> pending[0]=1, ir_req stays 0; write mask=4'b0001 -> ir_req=1 within 2 cycles, cause=0.
REQ-037 In REQ cause=1, ir_ack with new edge on irq_in[1] same cycle -> SERVICE, pending[1] remains 1; after eret line 1 requested again.
REQ-038 In SERVICE, irq_in[0] rises and ir_ack pulses -> ir_req stays 0, busy=1, pending[0]=1 until eret, then ir_req=1.
REQ-039 rst asserted in REQ -> next cycle ir_req=0, busy=0, pending=0, mask=0.
